// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one cacheline-granular memory port between the L1
// instruction and data cache controllers, one transaction at a time.
// Optional macro ARB_ROUND_ROBIN_EN: when defined, a tie in IDLE goes to the
// side opposite the last grant; when undefined, the D-cache always wins a tie.
// Request address, op and writeback data are latched when the grant starts.
// The returned line lands in a per-side rdata register.
// The served side gets a one-cycle resp pulse.

module l1_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESPOND} state_t;

  state_t state;
  logic   last_grant;   // 0: I-cache served last, 1: D-cache served last
  logic   resp_q;       // high for the single RESPOND cycle
  logic   d_req;
  logic   pick_d;

  // Decide which side an IDLE cycle would grant to
  always_comb begin
    d_req  = d_read | d_write;
    pick_d = d_req;
    if (d_req && i_read) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_d = ~last_grant;
`else
      pick_d = 1'b1;
`endif
    end
  end

  // The pulse goes to whichever side was just recorded as served
  assign i_resp = resp_q & ~last_grant;
  assign d_resp = resp_q &  last_grant;

  // Arbitration FSM with registered memory-side and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b0;
      resp_q      <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_q <= 1'b0;
          if (i_read || d_req) begin
            mem_address <= pick_d ? d_address : i_address;
            mem_write   <= pick_d & d_write;
            mem_read    <= ~(pick_d & d_write);
            if (pick_d && d_write) begin
              mem_wdata <= d_wdata;
            end
            state <= pick_d ? GRANT_D : GRANT_I;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_resp) begin
            if (!mem_write) begin
              if (state == GRANT_D) begin
                d_rdata <= mem_rdata;
              end else begin
                i_rdata <= mem_rdata;
              end
            end
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            last_grant <= (state == GRANT_D);
            resp_q     <= 1'b1;
            state      <= RESPOND;
          end
        end
        RESPOND: begin
          resp_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          resp_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter: transaction-level reference model of the L1 arbiter.
// Directed scenarios are followed by randomized request patterns, memory
// latencies and data. Honours ARB_ROUND_ROBIN_EN the same way the design does.

module tb_l1_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_read, d_read, d_write, mem_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, mem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_resp, d_resp, mem_read, mem_write;
  logic [AW-1:0] mem_address;

  int checks   = 0;
  int failures = 0;

  // Reference model state: who was served last, lines each cache last got,
  // and the writeback data the memory port should currently present
  bit            lastGrantModel;
  logic [LW-1:0] iLineModel, dLineModel, memWdataModel;

  l1_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] randLine();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic checkMemSide(input string tag, input bit expRd, input bit expWr, input logic [AW-1:0] expA);
    checkOutput($sformatf("%s.mem_read", tag), mem_read, expRd);
    checkOutput($sformatf("%s.mem_write", tag), mem_write, expWr);
    checkOutput($sformatf("%s.mem_address", tag), mem_address, expA);
    checkOutput($sformatf("%s.mem_wdata", tag), mem_wdata, memWdataModel);
    checkOutput($sformatf("%s.i_resp", tag), i_resp, 1'b0);
    checkOutput($sformatf("%s.d_resp", tag), d_resp, 1'b0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput($sformatf("%s.mem_read", tag), mem_read, 1'b0);
    checkOutput($sformatf("%s.mem_write", tag), mem_write, 1'b0);
    checkOutput($sformatf("%s.i_resp", tag), i_resp, 1'b0);
    checkOutput($sformatf("%s.d_resp", tag), d_resp, 1'b0);
    checkOutput($sformatf("%s.i_rdata", tag), i_rdata, iLineModel);
    checkOutput($sformatf("%s.d_rdata", tag), d_rdata, dLineModel);
  endtask

  // Async reset applied mid-cycle; everything must be zero at once
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    #1;
    lastGrantModel = 1'b0;
    iLineModel = '0; dLineModel = '0; memWdataModel = '0;
    checkMemSide(tag, 1'b0, 1'b0, '0);
    checkOutput($sformatf("%s.i_rdata", tag), i_rdata, '0);
    checkOutput($sformatf("%s.d_rdata", tag), d_rdata, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One granted transaction, starting with the arbiter in IDLE
  task automatic applyStimulus(input string name, input logic iRd, input logic dRd, input logic dWr,
                               input logic [AW-1:0] iA, input logic [AW-1:0] dA, input logic [LW-1:0] wd,
                               input int lat, input logic [LW-1:0] rdat, input bit keep, output bit wonD);
    bit dReq, winD, expWr;
    logic [AW-1:0] expA;
    i_read = iRd; d_read = dRd; d_write = dWr;
    i_address = iA; d_address = dA; d_wdata = wd;
    dReq = dRd | dWr;
    if (iRd && dReq) begin
`ifdef ARB_ROUND_ROBIN_EN
      winD = (lastGrantModel == 1'b0);
`else
      winD = 1'b1;
`endif
    end else begin
      winD = dReq;
    end
    expWr = winD && dWr;
    expA  = winD ? dA : iA;
    if (expWr) memWdataModel = wd;
    @(posedge clk); #1;
    checkMemSide({name, ".grant"}, !expWr, expWr, expA);
    for (int k = 0; k < lat; k++) begin
      mem_rdata = randLine();
      d_wdata   = '0;
      i_address = $urandom();
      d_address = $urandom();
      @(posedge clk); #1;
      checkMemSide({name, ".hold"}, !expWr, expWr, expA);
    end
    mem_resp  = 1'b1;
    mem_rdata = rdat;
    @(posedge clk); #1;
    mem_resp  = 1'b0;
    mem_rdata = randLine();
    lastGrantModel = winD;
    if (!expWr) begin
      if (winD) dLineModel = rdat;
      else      iLineModel = rdat;
    end
    checkOutput({name, ".resp.mem_read"}, mem_read, 1'b0);
    checkOutput({name, ".resp.mem_write"}, mem_write, 1'b0);
    checkOutput({name, ".resp.i_resp"}, i_resp, !winD);
    checkOutput({name, ".resp.d_resp"}, d_resp, winD);
    checkOutput({name, ".resp.i_rdata"}, i_rdata, iLineModel);
    checkOutput({name, ".resp.d_rdata"}, d_rdata, dLineModel);
    if (!keep) begin
      if (winD) begin
        d_read = 1'b0; d_write = 1'b0;
      end else begin
        i_read = 1'b0;
      end
    end
    @(posedge clk); #1;
    checkIdle({name, ".bubble"});
    wonD = winD;
  endtask

  initial begin
    bit w;
    int pat;
    bit iRd, dRd, dWr;
    logic [AW-1:0] iA, dA;
    logic [LW-1:0] wd;

    rst_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    #2;
    doReset("rst0");

    // Reset while a writeback grant is in progress
    d_write = 1'b1; d_address = 32'h8000_0020; d_wdata = {8{32'hCAFE_F00D}};
    @(posedge clk); #1;
    checkOutput("rstmid.grant.mem_write", mem_write, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid.async.mem_write", mem_write, 1'b0);
    checkOutput("rstmid.async.mem_address", mem_address, '0);
    checkOutput("rstmid.async.mem_wdata", mem_wdata, '0);
    d_write = 1'b0;
    lastGrantModel = 1'b0;
    iLineModel = '0; dLineModel = '0; memWdataModel = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkIdle("rstmid.after");
    end

    applyStimulus("iread", 1, 0, 0, 32'h0000_1040, '0, '0, 3, {32{8'hA5}}, 0, w);
    applyStimulus("dwb", 0, 0, 1, '0, 32'h8000_0020, {8{32'h1234_5678}}, 2, randLine(), 0, w);

    // Ties from reset: D first, then the repeated tie follows the arbitration mode
    doReset("rst1");
    applyStimulus("tie1", 1, 1, 0, 32'h0000_2000, 32'h0000_3000, '0, 1, randLine(), 0, w);
    checkOutput("tie1.winner_is_d", w, 1'b1);
    applyStimulus("tie2", 1, 1, 0, 32'h0000_2000, 32'h0000_3040, '0, 1, randLine(), 0, w);
    if (w) applyStimulus("tie2.loser", 1, 0, 0, 32'h0000_2000, '0, '0, 0, randLine(), 0, w);
    else   applyStimulus("tie2.loser", 0, 1, 0, '0, 32'h0000_3040, '0, 0, randLine(), 0, w);

    // Read held through RESPOND, then writeback in the idle bubble
    applyStimulus("drd", 0, 1, 0, '0, 32'h0000_4000, '0, 1, randLine(), 1, w);
    applyStimulus("dwr", 0, 0, 1, '0, 32'h0000_4000, randLine(), 1, randLine(), 0, w);

    // Zero-wait memory
    applyStimulus("zw", 1, 0, 0, 32'h0000_5000, '0, '0, 0, randLine(), 0, w);

    // Random request mixes and latencies
    for (int n = 0; n < 40; n++) begin
      pat = $urandom_range(1, 3);
      iRd = (pat != 2);
      dRd = 1'b0; dWr = 1'b0;
      if (pat != 1) begin
        if ($urandom_range(0, 1) == 1) dWr = 1'b1; else dRd = 1'b1;
        if ($urandom_range(0, 7) == 0) begin dRd = 1'b1; dWr = 1'b1; end
      end
      iA = $urandom(); dA = $urandom(); wd = randLine();
      applyStimulus("rnd", iRd, dRd, dWr, iA, dA, wd, $urandom_range(0, 4), randLine(), bit'($urandom_range(0, 1)), w);
      if (pat == 3) begin
        if (w) applyStimulus("rnd.loser", 1, 0, 0, iA, dA, wd, $urandom_range(0, 4), randLine(), 0, w);
        else   applyStimulus("rnd.loser", 0, dRd, dWr, iA, dA, wd, $urandom_range(0, 4), randLine(), 0, w);
      end
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
